glow_irq_ctrl: RTL and testbench
================================

GLOW_IRQ_CTRL -- requirements
Module: glow_irq_ctrl

Interface
REQ-001 Parameter NCH, default 8, number of interrupt channels, legal range 1..32.
REQ-002 Parameter AW, default 24, vector address width.
REQ-003 Parameter VBASE, default 24'h000100, vector table base address.
REQ-004 Parameter VSTRIDE_LOG2, default 4, log2 of the vector spacing in bytes.
REQ-005 Parameter XBASE, default 8'h40, XCR address of register 0.
REQ-006 clk  input  1  single clock; every flop samples on the rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 irq  input  NCH  raw interrupt sources, asynchronous to clk.
REQ-009 INT  output  1  interrupt request to the core.
REQ-010 IVEC_addr  output  AW  vector address for the core.
REQ-011 IN_ISP  input  1  high while the core executes an interrupt service routine.
REQ-012 XCRa  input  8  XCR register address.
REQ-013 XCRi  input  8  XCR write data.
REQ-014 XCRo  output  8  XCR read data.
REQ-015 XCRcs  input  1  XCR chip select.
REQ-016 XCRwe  input  1  XCR write enable.

Function
REQ-017 Each irq bit SHALL pass a 2-flop synchronizer; source-to-pending latency is 3 clk.
REQ-018 The register map SHALL be:
- XBASE+0..3 EN[31:0] bytes, read/write.
- XBASE+4..7 PEND bytes, read; write-1-clear.
- XBASE+8..11 MODE bytes, read/write; 1=rising-edge, 0=level.
- XBASE+12 CTRL, bit0=GIE, read/write.
- XBASE+13 ACT, read only: bit7 valid, bits4:0 active id.
- XBASE+14 EOI, write any value.
REQ-019 Register bits at channel index >=NCH SHALL read 0 and ignore writes.
REQ-020 Writes SHALL commit when XCRcs&XCRwe at the clock edge; XCRo SHALL be a combinational read of the addressed register when XCRcs=1, else 0.
REQ-021 Edge channel: PEND SHALL set on a synchronized 0->1 transition and clear only by W1C or acceptance.
REQ-022 Level channel: PEND SHALL equal the synchronized level, and W1C SHALL have no effect.
REQ-023 A PEND set event and a W1C clear on the same bit in the same cycle SHALL resolve with set winning.
REQ-024 Priority SHALL be fixed: the lowest index among PEND&EN wins.
REQ-025 The FSM SHALL use states IDLE, REQ and SERVICE.
REQ-026 IDLE->REQ when GIE=1 and PEND&EN is nonzero. On that cycle, latch the winning id; drive IVEC_addr=VBASE+(id<<VSTRIDE_LOG2) and INT=1 from the next cycle.
REQ-027 In REQ, id and IVEC_addr SHALL stay frozen.
REQ-028 If the latched channel's PEND&EN drops, or GIE clears, before IN_ISP=1, the FSM SHALL withdraw to IDLE and drop INT the next cycle.
REQ-029 REQ->SERVICE on IN_ISP=1. Then INT=0, ACT.valid=1, and an edge channel's PEND bit clears in the same cycle.
REQ-030 SERVICE->IDLE on an EOI write or on IN_ISP falling, whichever comes first; ACT.valid=0 the next cycle.
REQ-031 No nesting: requests arriving in SERVICE SHALL stay pending and are arbitrated after return to IDLE.
REQ-032 The IVEC_addr sum SHALL be AW bits, wrapping modulo 2^AW.

Reset
REQ-033 During rst=1 the outputs SHALL be INT=0 and IVEC_addr=VBASE.
REQ-034 During rst=1, EN, PEND, MODE and GIE SHALL be 0, the synchronizers 0, the FSM in IDLE and ACT 0.
REQ-035 Reset asserted mid-REQ or mid-SERVICE SHALL abandon the request with no EOI required.

Structure
REQ-036 A shared package glow_pkg SHALL hold the FSM state typedef and the register offset constants (EN, PEND, MODE, CTRL, ACT, EOI).
REQ-037 One sub-module, glow_irq_sync, SHALL hold the per-channel synchronizer and rising-edge detector, instantiated NCH times.

Verification
REQ-038 Scenario: EN=0x08, MODE=0x08, GIE=1, pulse irq[3] -> PEND=0x08, INT=1 4 clk later, IVEC_addr=0x000130.
REQ-039 Scenario: irq[5] and irq[2] rise together, both enabled -> id=2 serviced first. After EOI, id=5 is requested with IVEC_addr=0x000150.
REQ-040 Scenario: level channel 1 goes low while in REQ -> INT drops the next cycle, FSM in IDLE, no ACT.valid.
REQ-041 Scenario: W1C of PEND bit 4 coincides with a new edge on irq[4] -> PEND bit 4 remains 1.
REQ-042 Scenario: NCH=32, VBASE=0xFFFF00, id=31 -> IVEC_addr=0x0000F0 (wrap).
REQ-043 Scenario: rst asserted in SERVICE -> next cycle INT=0, ACT=0, EN=0, and XCRo reads 0 at every register.

Source files
------------

// File: rtl/glow_pkg.sv
// Shared FSM state type and register map offsets for the glow interrupt controller.
// Offsets are relative to the controller's XCR base address.
package glow_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } glow_state_e;

    localparam logic [7:0] OFF_EN   = 8'd0;
    localparam logic [7:0] OFF_PEND = 8'd4;
    localparam logic [7:0] OFF_MODE = 8'd8;
    localparam logic [7:0] OFF_CTRL = 8'd12;
    localparam logic [7:0] OFF_ACT  = 8'd13;
    localparam logic [7:0] OFF_EOI  = 8'd14;

    localparam int unsigned MAX_CH = 32;

    function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] sel);
        return word[{sel, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/glow_irq_sync.sv
// Two-flop synchronizer for one interrupt source, plus a rising-edge detector
// on the synchronized level.
module glow_irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~s3_q;

endmodule

// File: rtl/glow_irq_ctrl.sv
// Fixed-priority interrupt controller: per-channel enable/pending/mode registers on the
// XCR bus, lowest-index arbitration and a non-nesting request/service handshake.
module glow_irq_ctrl
    import glow_pkg::*;
#(
    parameter int unsigned   NCH          = 8,
    parameter int unsigned   AW           = 24,
    parameter logic [AW-1:0] VBASE        = 'h000100,
    parameter int unsigned   VSTRIDE_LOG2 = 4,
    parameter logic [7:0]    XBASE        = 8'h40
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] irq,
    output logic           INT,
    output logic [AW-1:0]  IVEC_addr,
    input  logic           IN_ISP,
    input  logic [7:0]     XCRa,
    input  logic [7:0]     XCRi,
    output logic [7:0]     XCRo,
    input  logic           XCRcs,
    input  logic           XCRwe
);

    logic [NCH-1:0] lvl, rise;
    logic [NCH-1:0] en_q, en_d;
    logic [NCH-1:0] mode_q, mode_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic           gie_q, gie_d;
    logic [NCH-1:0] we_en, we_mode, w1c, acc_clr;

    glow_state_e    state_q;
    logic [4:0]     id_q;
    logic [4:0]     win;
    logic           act_valid_q;
    logic [7:0]     act_byte;

    logic [7:0]     rel;
    logic           wr, eoi_wr, accept;
    logic [31:0]    en32, pend32, mode32, req32;
    logic [AW-1:0]  voff;

    for (genvar g = 0; g < NCH; g++) begin : g_sync
        glow_irq_sync u_sync (
            .clk   (clk),
            .rst   (rst),
            .d     (irq[g]),
            .level (lvl[g]),
            .rise  (rise[g])
        );
    end

    assign rel    = XCRa - XBASE;
    assign wr     = XCRcs & XCRwe;
    assign eoi_wr = wr && (rel == OFF_EOI);

    assign en32   = 32'(en_q);
    assign pend32 = 32'(pend_q);
    assign mode32 = 32'(mode_q);
    assign req32  = en32 & pend32;

    // Lowest pending+enabled index wins.
    always_comb begin
        win = 5'd0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req32[i]) begin
                win = 5'(i);
            end
        end
    end

    assign voff   = AW'(win) << VSTRIDE_LOG2;
    assign accept = (state_q == REQ) && gie_q && req32[id_q] && IN_ISP;

    // Per-bit write strobes; bits beyond NCH simply do not exist.
    always_comb begin
        we_en   = '0;
        we_mode = '0;
        w1c     = '0;
        acc_clr = '0;
        for (int i = 0; i < NCH; i++) begin
            we_en[i]   = wr && (rel == OFF_EN + 8'(i / 8));
            we_mode[i] = wr && (rel == OFF_MODE + 8'(i / 8));
            w1c[i]     = wr && (rel == OFF_PEND + 8'(i / 8)) && XCRi[3'(i)];
            acc_clr[i] = accept && (id_q == 5'(i));
        end
    end

    always_comb begin
        en_d   = en_q;
        mode_d = mode_q;
        for (int i = 0; i < NCH; i++) begin
            if (we_en[i]) begin
                en_d[i] = XCRi[3'(i)];
            end
            if (we_mode[i]) begin
                mode_d[i] = XCRi[3'(i)];
            end
        end
        gie_d  = (wr && (rel == OFF_CTRL)) ? XCRi[0] : gie_q;
        // Edge channels latch until cleared, and a fresh edge beats a same-cycle clear;
        // level channels just mirror the synchronized input.
        pend_d = (mode_q & (rise | (pend_q & ~w1c & ~acc_clr))) | (~mode_q & lvl);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q   <= '0;
            mode_q <= '0;
            pend_q <= '0;
            gie_q  <= 1'b0;
        end else begin
            en_q   <= en_d;
            mode_q <= mode_d;
            pend_q <= pend_d;
            gie_q  <= gie_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            id_q        <= 5'd0;
            INT         <= 1'b0;
            IVEC_addr   <= VBASE;
            act_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gie_q && (req32 != 32'd0)) begin
                        state_q   <= REQ;
                        id_q      <= win;
                        INT       <= 1'b1;
                        IVEC_addr <= VBASE + voff;
                    end
                end
                REQ: begin
                    if (!gie_q || !req32[id_q]) begin
                        state_q <= IDLE;
                        INT     <= 1'b0;
                    end else if (IN_ISP) begin
                        state_q     <= SERVICE;
                        INT         <= 1'b0;
                        act_valid_q <= 1'b1;
                    end
                end
                SERVICE: begin
                    if (eoi_wr || !IN_ISP) begin
                        state_q     <= IDLE;
                        act_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    INT         <= 1'b0;
                    act_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign act_byte = {act_valid_q, 2'b00, act_valid_q ? id_q : 5'd0};

    always_comb begin
        XCRo = 8'h00;
        if (XCRcs) begin
            if (rel[7:2] == OFF_EN[7:2]) begin
                XCRo = byte_of(en32, rel[1:0]);
            end else if (rel[7:2] == OFF_PEND[7:2]) begin
                XCRo = byte_of(pend32, rel[1:0]);
            end else if (rel[7:2] == OFF_MODE[7:2]) begin
                XCRo = byte_of(mode32, rel[1:0]);
            end else if (rel == OFF_CTRL) begin
                XCRo = {7'b0, gie_q};
            end else if (rel == OFF_ACT) begin
                XCRo = act_byte;
            end
        end
    end

endmodule

// File: tb/tb_glow_irq_ctrl.sv
// Directed bench for glow_irq_ctrl: a cycle-level behavioural model checks the outputs
// on every negative edge, and literal expectations pin the key scenarios.
module tb_glow_irq_ctrl;

    localparam logic [7:0]  XB     = 8'h40;
    localparam int unsigned VB     = 32'h100;
    localparam int unsigned CHMASK = 32'hFF;

    logic        clk, rst;
    logic [7:0]  irq;
    logic        INT, IN_ISP;
    logic [23:0] IVEC_addr;
    logic [7:0]  XCRa, XCRi, XCRo;
    logic        XCRcs, XCRwe;

    logic [31:0] irq2;
    logic        int2, isp2;
    logic [23:0] ivec2;
    logic [7:0]  xa2, xi2, xo2;
    logic        cs2, we2;

    glow_irq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .irq       (irq),
        .INT       (INT),
        .IVEC_addr (IVEC_addr),
        .IN_ISP    (IN_ISP),
        .XCRa      (XCRa),
        .XCRi      (XCRi),
        .XCRo      (XCRo),
        .XCRcs     (XCRcs),
        .XCRwe     (XCRwe)
    );

    glow_irq_ctrl #(
        .NCH   (32),
        .VBASE (24'hFFFF00)
    ) dut32 (
        .clk       (clk),
        .rst       (rst),
        .irq       (irq2),
        .INT       (int2),
        .IVEC_addr (ivec2),
        .IN_ISP    (isp2),
        .XCRa      (xa2),
        .XCRi      (xi2),
        .XCRo      (xo2),
        .XCRcs     (cs2),
        .XCRwe     (we2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: registers as plain integers, synchronizer as a sample history.
    int unsigned m_en, m_mode, m_pend, m_id, m_ivec;
    int unsigned h0, h1, h2;
    bit          m_gie, started;
    int          phase;  // 0 idle, 1 requesting, 2 in service

    function automatic int unsigned m_read(input logic [7:0] a);
        int unsigned r;
        r = 32'(8'(a - XB));
        if (r < 4)   return (m_en >> (8 * r)) & 32'hFF;
        if (r < 8)   return (m_pend >> (8 * (r - 4))) & 32'hFF;
        if (r < 12)  return (m_mode >> (8 * (r - 8))) & 32'hFF;
        if (r == 12) return 32'(m_gie);
        if (r == 13) return (phase == 2) ? (32'h80 | m_id) : 32'd0;
        return 32'd0;
    endfunction

    initial begin
        int unsigned req, lvl, rise, acc, w1c, r, d;
        bit wr;
        started = 1'b0;
        forever begin
            @(negedge clk);
            if (started) begin
                check("int", 32'(INT), (phase == 1) ? 32'd1 : 32'd0);
                check("ivec", 32'(IVEC_addr), m_ivec);
                check("xcro", 32'(XCRo), XCRcs ? m_read(XCRa) : 32'd0);
            end
            if (rst) begin
                m_en = 0; m_mode = 0; m_pend = 0; m_gie = 0; m_id = 0; m_ivec = VB;
                h0 = 0; h1 = 0; h2 = 0; phase = 0;
                started = 1'b1;
            end else begin
                wr   = XCRcs && XCRwe;
                r    = 32'(8'(XCRa - XB));
                d    = 32'(XCRi);
                lvl  = h1;
                rise = h1 & ~h2;
                req  = m_pend & m_en;
                acc  = 0;
                case (phase)
                    0: if (m_gie && req != 0) begin
                        m_id   = $clog2(req & (~req + 1));
                        m_ivec = (VB + m_id * 16) & 32'hFFFFFF;
                        phase  = 1;
                    end
                    1: if (!m_gie || ((req >> m_id) & 1) == 0) begin
                        phase = 0;
                    end else if (IN_ISP) begin
                        phase = 2;
                        acc   = 32'd1 << m_id;
                    end
                    default: if ((wr && r == 14) || !IN_ISP) phase = 0;
                endcase
                w1c    = (wr && r >= 4 && r < 8) ? (d << (8 * (r - 4))) : 0;
                m_pend = ((m_mode & (rise | (m_pend & ~w1c & ~acc))) | (~m_mode & lvl)) & CHMASK;
                if (wr && r < 4)
                    m_en = ((m_en & ~(32'hFF << (8 * r))) | (d << (8 * r))) & CHMASK;
                if (wr && r >= 8 && r < 12)
                    m_mode = ((m_mode & ~(32'hFF << (8 * (r - 8)))) | (d << (8 * (r - 8)))) & CHMASK;
                if (wr && r == 12) m_gie = d[0];
                h2 = h1; h1 = h0; h0 = 32'(irq);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xw(input logic [7:0] a, input logic [7:0] v);
        XCRcs = 1'b1; XCRwe = 1'b1; XCRa = a; XCRi = v;
        tick();
        XCRcs = 1'b0; XCRwe = 1'b0;
    endtask

    task automatic xr(input string name, input logic [7:0] a, input logic [7:0] exp);
        XCRcs = 1'b1; XCRa = a;
        #1;
        check(name, 32'(XCRo), 32'(exp));
        XCRcs = 1'b0;
    endtask

    task automatic xw2(input logic [7:0] a, input logic [7:0] v);
        cs2 = 1'b1; we2 = 1'b1; xa2 = a; xi2 = v;
        tick();
        cs2 = 1'b0; we2 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq = '0; IN_ISP = 1'b0;
        XCRa = '0; XCRi = '0; XCRcs = 1'b0; XCRwe = 1'b0;
        irq2 = '0; isp2 = 1'b0; xa2 = '0; xi2 = '0; cs2 = 1'b0; we2 = 1'b0;
        repeat (3) tick();
        check("rst_int", 32'(INT), 32'd0);
        check("rst_ivec", 32'(IVEC_addr), 32'h000100);
        for (int a = 0; a < 15; a++) xr("rst_reg", XB + 8'(a), 8'h00);
        rst = 1'b0;
        tick();

        // Vector address wraps modulo 2^24 on the 32-channel instance.
        xw2(XB + 8'd3, 8'h80);
        xw2(XB + 8'd11, 8'h80);
        xw2(XB + 8'd12, 8'h01);
        irq2[31] = 1'b1; tick(); irq2[31] = 1'b0;
        repeat (3) tick();
        check("wrap_int", 32'(int2), 32'd1);
        check("wrap_ivec", 32'(ivec2), 32'h0000F0);

        // Single edge source on channel 3.
        xw(XB + 8'd0, 8'h08);
        xw(XB + 8'd8, 8'h08);
        xw(XB + 8'd12, 8'h01);
        irq[3] = 1'b1; tick(); irq[3] = 1'b0;
        tick(); tick();
        xr("ch3_pend", XB + 8'd4, 8'h08);
        check("ch3_int_early", 32'(INT), 32'd0);
        tick();
        check("ch3_int", 32'(INT), 32'd1);
        check("ch3_ivec", 32'(IVEC_addr), 32'h000130);
        IN_ISP = 1'b1; tick();
        check("ch3_svc_int", 32'(INT), 32'd0);
        xr("ch3_act", XB + 8'd13, 8'h83);
        xr("ch3_pend_clr", XB + 8'd4, 8'h00);
        xw(XB + 8'd14, 8'h00);
        xr("ch3_act_eoi", XB + 8'd13, 8'h00);
        IN_ISP = 1'b0; tick();

        // Channels 5 and 2 together: 2 first, then 5 after EOI.
        xw(XB + 8'd0, 8'h24);
        xw(XB + 8'd8, 8'h24);
        irq = 8'h24; tick(); irq = 8'h00;
        repeat (3) tick();
        check("pri_ivec2", 32'(IVEC_addr), 32'h000120);
        IN_ISP = 1'b1; tick();
        xr("pri_act2", XB + 8'd13, 8'h82);
        xr("pri_pend5", XB + 8'd4, 8'h20);
        xw(XB + 8'd14, 8'h00);
        IN_ISP = 1'b0; tick();
        check("pri_int5", 32'(INT), 32'd1);
        check("pri_ivec5", 32'(IVEC_addr), 32'h000150);
        IN_ISP = 1'b1; tick();
        xr("pri_act5", XB + 8'd13, 8'h85);
        IN_ISP = 1'b0; tick();
        xr("pri_act_done", XB + 8'd13, 8'h00);

        // Level channel 1 drops while requesting: withdraw.
        xw(XB + 8'd0, 8'h02);
        xw(XB + 8'd8, 8'h00);
        irq[1] = 1'b1;
        repeat (4) tick();
        check("lvl_int", 32'(INT), 32'd1);
        check("lvl_ivec", 32'(IVEC_addr), 32'h000110);
        irq[1] = 1'b0;
        repeat (3) tick();
        check("lvl_int_hold", 32'(INT), 32'd1);
        tick();
        check("lvl_int_drop", 32'(INT), 32'd0);
        xr("lvl_act", XB + 8'd13, 8'h00);
        repeat (2) tick();

        // W1C on channel 4 in the same cycle as a new edge: set wins.
        xw(XB + 8'd12, 8'h00);
        xw(XB + 8'd0, 8'h10);
        xw(XB + 8'd8, 8'h10);
        irq[4] = 1'b1; tick(); irq[4] = 1'b0; tick();
        xw(XB + 8'd4, 8'h10);
        xr("w1c_race", XB + 8'd4, 8'h10);
        xw(XB + 8'd4, 8'h10);
        xr("w1c_clear", XB + 8'd4, 8'h00);

        // Reset while in service abandons everything.
        xw(XB + 8'd0, 8'h01);
        xw(XB + 8'd8, 8'h01);
        xw(XB + 8'd12, 8'h01);
        irq[0] = 1'b1; tick(); irq[0] = 1'b0;
        repeat (3) tick();
        check("svc_int", 32'(INT), 32'd1);
        IN_ISP = 1'b1; tick();
        xr("svc_act", XB + 8'd13, 8'h80);
        rst = 1'b1; tick();
        check("rst_svc_int", 32'(INT), 32'd0);
        for (int a = 0; a < 15; a++) xr("rst_svc_reg", XB + 8'(a), 8'h00);
        rst = 1'b0; IN_ISP = 1'b0;
        repeat (3) tick();
        check("post_rst_int", 32'(INT), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
